// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: hazard stall, branch squash, memory freeze, perf counters.
// Optional feature macro: HAZ_EXFWD_EN (EX/MEM forwarding present; only load-use and BR-source hazards stall).
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic [3:0]  id_dst,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_branch_reg,
  input  logic        br_taken,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_freeze,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles,
  output logic [15:0] freeze_cycles
);

  typedef struct packed {
    logic       v;
    logic [3:0] dst;
    logic       rw;
    logic       mr;
  } slot_t;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HAZ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  slot_t      ex_q, mem_q, ex_d, mem_d;
  state_t     state_q, state_d;
  logic [7:0] run_q, run_d;
  logic       hazard;
  logic       rd1;

  function automatic logic match(input slot_t s, input logic [3:0] r);
    return s.v && s.rw && (s.dst == r) && (r != 4'd0);
  endfunction

  // A BR instruction reads src1 as its target even if id_use1 is not flagged.
  assign rd1 = id_use1 | id_branch_reg;

  always_comb begin
    hazard = 1'b0;
`ifdef HAZ_EXFWD_EN
    if (id_valid) begin
      hazard = (((rd1 && match(ex_q, id_src1)) || (id_use2 && match(ex_q, id_src2))) && ex_q.mr)
             || (id_branch_reg && (match(ex_q, id_src1) || (match(mem_q, id_src1) && mem_q.mr)));
    end
`else
    if (id_valid) begin
      hazard = (rd1 && (match(ex_q, id_src1) || match(mem_q, id_src1)))
             || (id_use2 && (match(ex_q, id_src2) || match(mem_q, id_src2)));
    end
`endif
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    state_d     = S_RUN;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      state_d     = S_WAIT;
    end else if (hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_d     = S_HAZ;
    end else begin
      ifid_flush  = id_valid & br_taken;
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (!mem_busy) begin
      mem_d = ex_q;
      if (hazard) begin
        ex_d.v = 1'b0;
      end else begin
        ex_d = '{v: id_valid, dst: id_dst, rw: id_regwrite, mr: id_memread};
      end
    end
  end

  // Busy run length: a WAIT state means the previous cycle was already frozen.
  always_comb begin
    run_d = '0;
    if (mem_busy) begin
      if (state_q == S_WAIT) begin
        run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
      end else begin
        run_d = 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q          <= '0;
      mem_q         <= '0;
      state_q       <= S_RUN;
      run_q         <= '0;
      mem_timeout   <= 1'b0;
      stall_cycles  <= '0;
      freeze_cycles <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      state_q <= state_d;
      run_q   <= run_d;
      if (mem_busy && (32'(run_d) >= TIMEOUT)) begin
        mem_timeout <= 1'b1;
      end
      if (mem_busy) begin
        if (freeze_cycles != 16'hFFFF) begin
          freeze_cycles <= freeze_cycles + 16'd1;
        end
      end else if (hazard) begin
        if (stall_cycles != 16'hFFFF) begin
          stall_cycles <= stall_cycles + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an instruction-history model.
module tb_hazard_ctrl;

  localparam int unsigned TMO = 4;
`ifdef HAZ_EXFWD_EN
  localparam int LU_STALLS = 1;
  localparam int BR_STALLS = 1;
`else
  localparam int LU_STALLS = 2;
  localparam int BR_STALLS = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_src1, id_src2, id_dst;
  logic        id_use1, id_use2, id_regwrite, id_memread, id_branch_reg, br_taken, mem_busy;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout;
  logic [15:0] stall_cycles, freeze_cycles;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
    .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_branch_reg(id_branch_reg), .br_taken(br_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .freeze_cycles(freeze_cycles)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[0] is the instruction issued one cycle ahead, hist[1] two cycles ahead.
  typedef struct packed {
    logic       v;
    logic [3:0] dst;
    logic       rw;
    logic       mr;
  } ins_t;

  ins_t hist [2];
  int   m_stall, m_freeze, m_run;
  bit   m_tmo;
  bit   started = 1'b0;

  function automatic bit writes_reg(input ins_t i, input logic [3:0] r);
    return i.v && i.rw && (i.dst == r) && (r != 4'd0);
  endfunction

  function automatic bit model_hazard();
    logic [3:0] srcs[$];
    if (!id_valid) return 1'b0;
    if (id_use1 || id_branch_reg) srcs.push_back(id_src1);
    if (id_use2) srcs.push_back(id_src2);
`ifdef HAZ_EXFWD_EN
    foreach (srcs[k]) if (writes_reg(hist[0], srcs[k]) && hist[0].mr) return 1'b1;
    if (id_branch_reg && (writes_reg(hist[0], id_src1) ||
                          (writes_reg(hist[1], id_src1) && hist[1].mr))) return 1'b1;
`else
    foreach (srcs[k])
      for (int d = 0; d < 2; d++) if (writes_reg(hist[d], srcs[k])) return 1'b1;
`endif
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hist[0]  <= '0;
      hist[1]  <= '0;
      m_stall  <= 0;
      m_freeze <= 0;
      m_run    <= 0;
      m_tmo    <= 1'b0;
      started  <= 1'b1;
    end else if (mem_busy) begin
      m_freeze <= (m_freeze < 65535) ? m_freeze + 1 : m_freeze;
      m_run    <= m_run + 1;
      if (m_run + 1 >= int'(TMO)) m_tmo <= 1'b1;
    end else begin
      m_run   <= 0;
      hist[1] <= hist[0];
      if (model_hazard()) begin
        m_stall <= (m_stall < 65535) ? m_stall + 1 : m_stall;
        hist[0] <= '0;
      end else begin
        hist[0] <= '{v: id_valid, dst: id_dst, rw: id_regwrite, mr: id_memread};
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit h, e_pc, e_flush, e_bub, e_frz;
      h = model_hazard();
      if (rst) begin
        e_pc = 0; e_flush = 1; e_bub = 1; e_frz = 0;
      end else if (mem_busy) begin
        e_pc = 0; e_flush = 0; e_bub = 0; e_frz = 1;
      end else if (h) begin
        e_pc = 0; e_flush = 0; e_bub = 1; e_frz = 0;
      end else begin
        e_pc = 1; e_flush = id_valid & br_taken; e_bub = 0; e_frz = 0;
      end
      cmp("pc_write", 16'(pc_write), 16'(e_pc));
      cmp("ifid_write", 16'(ifid_write), 16'(e_pc));
      cmp("ifid_flush", 16'(ifid_flush), 16'(e_flush));
      cmp("idex_bubble", 16'(idex_bubble), 16'(e_bub));
      cmp("pipe_freeze", 16'(pipe_freeze), 16'(e_frz));
      cmp("mem_timeout", 16'(mem_timeout), 16'(m_tmo));
      cmp("stall_cycles", stall_cycles, 16'(m_stall));
      cmp("freeze_cycles", freeze_cycles, 16'(m_freeze));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [3:0] s1, input logic u1,
                        input logic [3:0] s2, input logic u2, input logic [3:0] d,
                        input logic rw, input logic mr, input logic br,
                        input logic bt, input logic busy);
    id_valid = v; id_src1 = s1; id_use1 = u1; id_src2 = s2; id_use2 = u2;
    id_dst = d; id_regwrite = rw; id_memread = mr; id_branch_reg = br;
    br_taken = bt; mem_busy = busy;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Holds the current decode inputs until the stall clears; returns stall length.
  task automatic count_stall(output int n, input string name, input bit chk_flush);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      #2;
      if (idex_bubble !== 1'b1) break;
      if (chk_flush) cmp({name, "_noflush"}, 16'(ifid_flush), 16'd0);
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int busy_left;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    #2;
    cmp("rst_flush", 16'(ifid_flush), 16'd1);
    cmp("rst_bubble", 16'(idex_bubble), 16'd1);
    cmp("rst_pc", 16'(pc_write), 16'd0);
    cmp("rst_stall", stall_cycles, 16'd0);
    cmp("rst_freeze", freeze_cycles, 16'd0);
    tick();
    rst = 1'b0;

    // independent instructions
    for (int i = 1; i <= 4; i++) begin
      set_in(1, 4'(i + 8), 1, 4'(i + 9), 1, 4'(i), 1, 0, 0, 0, 0);
      #2;
      cmp("indep_pc", 16'(pc_write), 16'd1);
      tick();
    end
    #2;
    cmp("indep_stall", stall_cycles, 16'd0);
    tick();

    // load-use: LW R3 ; ADD R4,R3,R5
    do_reset();
    set_in(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    tick();
    set_in(1, 3, 1, 5, 1, 4, 1, 0, 0, 0, 0);
    count_stall(n, "lu", 0);
    cmp("lu_len", 16'(n), 16'(LU_STALLS));
    cmp("lu_cnt", stall_cycles, 16'(LU_STALLS));
    tick();

    // R0 source and unused source never stall
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    set_in(1, 0, 1, 2, 1, 1, 1, 0, 0, 0, 0);
    #2;
    cmp("r0_bubble", 16'(idex_bubble), 16'd0);
    tick();
    set_in(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
    tick();
    set_in(1, 9, 1, 6, 0, 2, 1, 0, 0, 0, 0);
    #2;
    cmp("unused_bubble", 16'(idex_bubble), 16'd0);
    tick();

    // BR R7 after ADD R7, branch taken
    do_reset();
    set_in(1, 1, 1, 2, 1, 7, 1, 0, 0, 0, 0);
    tick();
    set_in(1, 7, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    count_stall(n, "br", 1);
    cmp("br_len", 16'(n), 16'(BR_STALLS));
    cmp("br_flush", 16'(ifid_flush), 16'd1);
    tick();
    set_in(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);
    #2;
    cmp("br_after", 16'(ifid_flush), 16'd0);
    tick();

    // freeze during load-use hazard
    do_reset();
    set_in(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_in(1, 3, 1, 5, 1, 4, 1, 0, 0, 0, 1);
      #2;
      cmp("frz_freeze", 16'(pipe_freeze), 16'd1);
      cmp("frz_bubble", 16'(idex_bubble), 16'd0);
      tick();
    end
    mem_busy = 1'b0;
    #2;
    cmp("frz_cnt", freeze_cycles, 16'd3);
    count_stall(n, "frz", 0);
    cmp("frz_stall", 16'(n), 16'(LU_STALLS));
    tick();

    // timeout with TIMEOUT=4
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      mem_busy = 1'b1;
      #2;
      cmp("tmo_busy", 16'(mem_timeout), 16'(k >= 5));
      tick();
    end
    mem_busy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #2;
      cmp("tmo_sticky", 16'(mem_timeout), 16'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    cmp("tmo_clear", 16'(mem_timeout), 16'd0);
    tick();

    // randomized traffic
    busy_left = 0;
    for (int c = 0; c < 4000; c++) begin
      logic br;
      br = ($urandom_range(0, 7) == 0);
      set_in($urandom_range(0, 5) != 0, 4'($urandom_range(0, 7)), br | 1'($urandom),
             4'($urandom_range(0, 7)), 1'($urandom), 4'($urandom_range(0, 7)),
             1'($urandom), ($urandom_range(0, 2) == 0), br, 1'($urandom), 1'b0);
      if (busy_left > 0) begin
        mem_busy = 1'b1;
        busy_left--;
      end else if ($urandom_range(0, 9) == 0) begin
        mem_busy = 1'b1;
        busy_left = $urandom_range(0, 6);
      end
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
